// File: rtl/fifo_drain_rd.sv
// fifo_drain_rd: read-side drain engine for the 16-bit synchronous FIFO.
// Pops words through the FIFO readp/emptyp/dout handshake, absorbs the
// one-cycle registered-dout latency in a small circular buffer and presents
// the words on a valid/ready stream at one word per clock.
// Optional feature macro: FIFO_DRAIN_PARITY_EN adds out_parity, the XOR of
// out_data, computed when the word is captured and stored alongside it.
module fifo_drain_rd #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned BUF_DEPTH = 3,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rstp,
    input  logic              drain_en,
    input  logic              fifo_emptyp,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_readp,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  word_cnt
`ifdef FIFO_DRAIN_PARITY_EN
    ,
    output logic              out_parity
`endif
);

    // BUF_DEPTH is limited to 2..4, so two pointer bits and three
    // occupancy bits always suffice (occ + inflight never exceeds 5).
    localparam int unsigned PTR_W = (BUF_DEPTH > 2) ? 2 : 1;
    localparam int unsigned OCC_W = 3;
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(BUF_DEPTH - 1);
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(BUF_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               inflight_q, inflight_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  mem_q [BUF_DEPTH];
    logic [DATA_W-1:0]  mem_d [BUF_DEPTH];
`ifdef FIFO_DRAIN_PARITY_EN
    logic               par_q [BUF_DEPTH];
    logic               par_d [BUF_DEPTH];
`endif

    logic               room;
    logic               capture;
    logic               xfer;
    logic               drained;

    // Pop request, stream outputs and buffer/pointer/counter next values.
    always_comb begin
        room       = (occ_q + OCC_W'(inflight_q)) < DEPTH_OCC;
        fifo_readp = drain_en & ~fifo_emptyp & room & ~rstp;
        out_valid  = (occ_q != '0);
        out_data   = mem_q[rd_ptr_q];
        busy       = (state_q != IDLE);
        word_cnt   = cnt_q;
`ifdef FIFO_DRAIN_PARITY_EN
        out_parity = par_q[rd_ptr_q];
`endif

        capture    = inflight_q;
        xfer       = out_valid & out_ready;
        drained    = (occ_q == '0) & ~inflight_q;

        inflight_d = fifo_readp;
        mem_d      = mem_q;
`ifdef FIFO_DRAIN_PARITY_EN
        par_d      = par_q;
`endif
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        cnt_d      = cnt_q;

        if (capture) begin
            mem_d[wr_ptr_q] = fifo_dout;
`ifdef FIFO_DRAIN_PARITY_EN
            par_d[wr_ptr_q] = ^fifo_dout;
`endif
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (xfer) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            cnt_d    = cnt_q + 1'b1;
        end
        // Capture and transfer in the same cycle leave occupancy unchanged.
        if (capture && !xfer) begin
            occ_d = occ_q + 1'b1;
        end else if (!capture && xfer) begin
            occ_d = occ_q - 1'b1;
        end
    end

    // Next-state logic for the IDLE / ACTIVE / FLUSH controller.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (drain_en && !fifo_emptyp) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (!drain_en) begin
                    state_d = FLUSH;
                end else if (fifo_emptyp && drained) begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                if (drain_en) begin
                    state_d = ACTIVE;
                end else if (drained) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pointer, counter and buffer registers; reset drops any pop in flight.
    always_ff @(posedge clk) begin
        if (rstp) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
            occ_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
`ifdef FIFO_DRAIN_PARITY_EN
                par_q[i] <= 1'b0;
`endif
            end
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            mem_q      <= mem_d;
`ifdef FIFO_DRAIN_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_drain_rd.sv
// tb_fifo_drain_rd: directed self-checking bench for fifo_drain_rd.
// The bench plays the FIFO itself (word queue, registered dout, empty flag)
// and records every word the consumer accepts.
module tb_fifo_drain_rd;

    logic        clk = 1'b0;
    logic        rstp;
    logic        drain_en;
    logic        fifo_emptyp;
    logic [15:0] fifo_dout;
    logic        fifo_readp;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic [15:0] word_cnt;
`ifdef FIFO_DRAIN_PARITY_EN
    logic        out_parity;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] fq[$];
    logic [15:0] rcv[$];
    logic        rcv_par[$];
    int          n_pops;
    int          n_xfer;
    int          cyc = 0;
    int          last_cyc;
    int          max_gap;

    fifo_drain_rd #(
        .DATA_W    (16),
        .BUF_DEPTH (3),
        .CNT_W     (16)
    ) dut (
        .clk         (clk),
        .rstp        (rstp),
        .drain_en    (drain_en),
        .fifo_emptyp (fifo_emptyp),
        .fifo_dout   (fifo_dout),
        .fifo_readp  (fifo_readp),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
`ifdef FIFO_DRAIN_PARITY_EN
        .out_parity  (out_parity),
`endif
        .word_cnt    (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [15:0] w);
        fq.push_back(w);
        fifo_emptyp = 1'b0;
    endtask

    // One clock: sample pre-edge handshakes, then update the FIFO model.
    task automatic step();
        logic        rd;
        logic        xf;
        logic [15:0] d;
        logic        p;
        #1;
        rd = fifo_readp;
        xf = out_valid & out_ready & ~rstp;
        d  = out_data;
`ifdef FIFO_DRAIN_PARITY_EN
        p  = out_parity;
`else
        p  = 1'b0;
`endif
        @(posedge clk);
        cyc++;
        if (rd) n_pops++;
        if (xf) begin
            rcv.push_back(d);
            rcv_par.push_back(p);
            n_xfer++;
            if (n_xfer > 1 && (cyc - last_cyc) > max_gap) max_gap = cyc - last_cyc;
            last_cyc = cyc;
        end
        #1;
        if (rstp) begin
            fq.delete();
            fifo_dout = '0;
        end else if (rd && fq.size() > 0) begin
            fifo_dout = fq.pop_front();
        end
        fifo_emptyp = (fq.size() == 0);
        @(negedge clk);
    endtask

    task automatic clear_log();
        rcv.delete();
        rcv_par.delete();
        n_pops   = 0;
        n_xfer   = 0;
        max_gap  = 0;
        last_cyc = 0;
    endtask

    task automatic do_reset();
        rstp      = 1'b1;
        drain_en  = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        rstp = 1'b0;
        clear_log();
    endtask

    task automatic run_until_idle(input string tag, input int bound);
        int k = 0;
        do begin
            step();
            k++;
        end while ((busy || out_valid) && k < bound);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int valid_seen;
        int pushed;
        int k;
        bit saw_ffff;

        rstp        = 1'b1;
        drain_en    = 1'b0;
        out_ready   = 1'b0;
        fifo_emptyp = 1'b1;
        fifo_dout   = '0;
        clear_log();
        @(negedge clk);

        // Reset state
        do_reset();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_cnt", {16'd0, word_cnt}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_data", {16'd0, out_data}, 32'd0);
        check("rst_readp", {31'd0, fifo_readp}, 32'd0);
`ifdef FIFO_DRAIN_PARITY_EN
        check("rst_parity", {31'd0, out_parity}, 32'd0);
`endif

        // Streaming 0x0001..0x0008
        for (int i = 1; i <= 8; i++) push(16'(i));
        drain_en  = 1'b1;
        out_ready = 1'b1;
        step();
        check("strm_valid_e1", {31'd0, out_valid}, 32'd0);
        check("strm_busy_e1", {31'd0, busy}, 32'd1);
        step();
        check("strm_valid_e2", {31'd0, out_valid}, 32'd1);
        check("strm_data_e2", {16'd0, out_data}, 32'h0001);
        run_until_idle("strm", 40);
        check("strm_n", 32'(rcv.size()), 32'd8);
        for (int i = 0; i < 8 && i < rcv.size(); i++)
            check("strm_word", {16'd0, rcv[i]}, 32'(i + 1));
        check("strm_gap", 32'(max_gap), 32'd1);
        check("strm_cnt", {16'd0, word_cnt}, 32'd8);

        // Backpressure
        do_reset();
        push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
        drain_en = 1'b1;
        repeat (6) step();
        check("bp_readp", {31'd0, fifo_readp}, 32'd0);
        check("bp_fifo_left", 32'(fq.size()), 32'd1);
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        check("bp_data", {16'd0, out_data}, 32'h1111);
        repeat (3) step();
        check("bp_data_hold", {16'd0, out_data}, 32'h1111);
        check("bp_pops", 32'(n_pops), 32'd3);
        out_ready = 1'b1;
        run_until_idle("bp", 20);
        check("bp_n", 32'(rcv.size()), 32'd4);
        for (int i = 0; i < 4 && i < rcv.size(); i++)
            check("bp_word", {16'd0, rcv[i]}, 32'h1111 * (i + 1));
        check("bp_cnt", {16'd0, word_cnt}, 32'd4);

        // Flush with a pop in flight, then resume
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) push(16'hA000 + 16'(i));
        drain_en = 1'b1;
        step();
        drain_en = 1'b0;
        #1;
        check("fl_readp_off", {31'd0, fifo_readp}, 32'd0);
        step();
        check("fl_busy", {31'd0, busy}, 32'd1);
        check("fl_valid", {31'd0, out_valid}, 32'd1);
        check("fl_data", {16'd0, out_data}, 32'hA001);
        run_until_idle("fl", 20);
        check("fl_pops", 32'(n_pops), 32'd1);
        check("fl_n", 32'(rcv.size()), 32'd1);
        if (rcv.size() > 0) check("fl_word", {16'd0, rcv[0]}, 32'hA001);
        check("fl_fifo_left", 32'(fq.size()), 32'd4);
        check("fl_cnt", {16'd0, word_cnt}, 32'd1);
        drain_en = 1'b1;
        step();
        run_until_idle("fl_resume", 20);
        check("fl_resume_n", 32'(rcv.size()), 32'd5);
        for (int i = 1; i < 5 && i < rcv.size(); i++)
            check("fl_resume_word", {16'd0, rcv[i]}, 32'hA001 + 32'(i));
        check("fl_resume_cnt", {16'd0, word_cnt}, 32'd5);

        // Empty guard
        do_reset();
        drain_en   = 1'b1;
        out_ready  = 1'b1;
        valid_seen = 0;
        repeat (20) begin
            step();
            if (out_valid) valid_seen++;
        end
        check("empty_pops", 32'(n_pops), 32'd0);
        check("empty_valid", 32'(valid_seen), 32'd0);
        check("empty_busy", {31'd0, busy}, 32'd0);

        // Reset mid-stream with a pop in flight
        do_reset();
        for (int i = 1; i <= 6; i++) push(16'hB000 + 16'(i));
        drain_en  = 1'b1;
        out_ready = 1'b1;
        repeat (3) step();
        check("mid_cnt_pre", {16'd0, word_cnt}, 32'd1);
        check("mid_fifo_pre", 32'(fq.size()), 32'd3);
        rstp = 1'b1;
        #1;
        check("mid_readp_rst", {31'd0, fifo_readp}, 32'd0);
        step();
        rstp = 1'b0;
        check("mid_valid", {31'd0, out_valid}, 32'd0);
        check("mid_cnt", {16'd0, word_cnt}, 32'd0);
        check("mid_busy", {31'd0, busy}, 32'd0);
        step();
        check("mid_valid_post", {31'd0, out_valid}, 32'd0);

        // Counter wrap: 65535 words, then 0x0007
        do_reset();
        drain_en  = 1'b1;
        out_ready = 1'b1;
        pushed    = 0;
        saw_ffff  = 1'b0;
        k         = 0;
        while (n_xfer < 65536 && k < 70000) begin
            if (pushed < 65535 && fq.size() < 4) begin
                push(16'(pushed));
                pushed++;
            end else if (pushed == 65535) begin
                push(16'h0007);
                pushed++;
            end
            step();
            k++;
            if (n_xfer == 65535 && !saw_ffff) begin
                saw_ffff = 1'b1;
                check("wrap_cnt_max", {16'd0, word_cnt}, 32'hFFFF);
            end
        end
        check("wrap_n", 32'(n_xfer), 32'd65536);
        check("wrap_cnt", {16'd0, word_cnt}, 32'h0000);
        if (rcv.size() == 65536) begin
            check("wrap_prev_word", {16'd0, rcv[65534]}, 32'hFFFE);
            check("wrap_last_word", {16'd0, rcv[65535]}, 32'h0007);
`ifdef FIFO_DRAIN_PARITY_EN
            check("wrap_parity", {31'd0, rcv_par[65535]}, 32'd1);
            check("wrap_parity_prev", {31'd0, rcv_par[65534]}, 32'd1);
`endif
        end
        run_until_idle("wrap", 20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
